// File: rtl/mnist_bin_pkg.sv
// Shared constants and state type for the MNIST pixel binarizer front end.
package mnist_bin_pkg;

  localparam int unsigned PIXELS = 784;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned CNT_W  = 10;

  typedef enum logic [0:0] {
    FILL,
    HOLD
  } state_e;

endpackage

// File: rtl/mnist_pix_counter.sv
// Pixel position counter: increments on inc_i, wraps after Last, clr_i has priority.
module mnist_pix_counter
  import mnist_bin_pkg::*;
#(
  parameter int unsigned Width = CNT_W,
  parameter int unsigned Last  = PIXELS - 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o,
  output logic             term_o
);

  localparam logic [Width-1:0] LastVal = Width'(Last);

  logic [Width-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == LastVal);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = term_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mnist_pixel_binarizer.sv
// Binarizes a greyscale pixel stream into a full MNIST frame register for layer0.
// Optional framing check via pix_last is enabled by defining MNIST_BIN_FRAMECHK_EN.
module mnist_pixel_binarizer
  import mnist_bin_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_last,
  input  logic [PIX_W-1:0]  thresh,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [PIXELS-1:0] frm_data
`ifdef MNIST_BIN_FRAMECHK_EN
  ,
  output logic              frm_err
`endif
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt;
  logic              term;
  logic              accept;
  logic              cnt_zero;
  logic [PIX_W-1:0]  thr;
  logic              pix_bit;
  logic              short_frame;
  logic [PIX_W-1:0]  thresh_q;
  logic [PIXELS-1:0] frm_data_q;

  assign accept   = pix_valid & pix_ready;
  assign cnt_zero = (cnt == '0);
  // First pixel of a frame compares against the live threshold, the rest against the latch.
  assign thr      = cnt_zero ? thresh : thresh_q;
  assign pix_bit  = (pix_data >= thr);

`ifdef MNIST_BIN_FRAMECHK_EN
  logic err_q;

  assign short_frame = accept & pix_last & ~term;
  assign frm_err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (short_frame || (accept && term && !pix_last)) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_pix_last;

  assign short_frame     = 1'b0;
  assign unused_pix_last = pix_last;
`endif

  mnist_pix_counter #(
    .Width (CNT_W),
    .Last  (PIXELS - 1)
  ) u_counter (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (accept & ~short_frame),
    .clr_i  (short_frame),
    .cnt_o  (cnt),
    .term_o (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_data_q <= '0;
      thresh_q   <= '0;
    end else if (accept) begin
      frm_data_q[cnt] <= pix_bit;
      if (cnt_zero) begin
        thresh_q <= thresh;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    frm_valid = 1'b0;
    unique case (state_q)
      FILL: begin
        pix_ready = 1'b1;
        if (accept && term) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        frm_valid = 1'b1;
        if (frm_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign frm_data = frm_data_q;

endmodule

// File: tb/tb_mnist_pixel_binarizer.sv
// Directed self-checking bench for mnist_pixel_binarizer.
module tb_mnist_pixel_binarizer;

  localparam int NPIX = 784;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pix_valid = 1'b0;
  logic            pix_ready;
  logic [7:0]      pix_data = 8'h00;
  logic            pix_last = 1'b0;
  logic [7:0]      thresh = 8'h00;
  logic            frm_valid;
  logic            frm_ready = 1'b0;
  logic [NPIX-1:0] frm_data;
`ifdef MNIST_BIN_FRAMECHK_EN
  logic            frm_err;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]      pix_mem [NPIX];
  logic [NPIX-1:0] exp_frame;
  logic            early_valid;

  always #5 clk = ~clk;

  mnist_pixel_binarizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_last  (pix_last),
    .thresh    (thresh),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .frm_data  (frm_data)
`ifdef MNIST_BIN_FRAMECHK_EN
    ,
    .frm_err   (frm_err)
`endif
  );

  // Streams pix_mem back to back; records whether frm_valid showed up before the last accept.
  task automatic run_frame(input logic [7:0] th0, input logic [7:0] th_rest);
    early_valid = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      pix_valid = 1'b1;
      pix_data  = pix_mem[i];
      thresh    = (i == 0) ? th0 : th_rest;
      pix_last  = (i == NPIX - 1);
      @(posedge clk);
      #1;
      if (i < NPIX - 1 && frm_valid) early_valid = 1'b1;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic release_frame();
    frm_ready = 1'b1;
    @(posedge clk);
    #1;
    frm_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tests_run++;
    if (pix_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pix_ready got %b want 1", pix_ready);
    end
    tests_run++;
    if (frm_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_frm_valid got %b want 0", frm_valid);
    end
    tests_run++;
    if (frm_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_frm_data got nonzero want 0");
    end
`ifdef MNIST_BIN_FRAMECHK_EN
    tests_run++;
    if (frm_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_frm_err got %b want 0", frm_err);
    end
`endif
  endtask

  task automatic test_alternating();
    for (int i = 0; i < NPIX; i++) begin
      pix_mem[i] = (i % 2 == 1) ? 8'h80 : 8'h7F;
      exp_frame[i] = (i % 2 == 1);
    end
    frm_ready = 1'b1;
    run_frame(8'd128, 8'd128);
    tests_run++;
    if (early_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL alt_early_valid got %b want 0", early_valid);
    end
    tests_run++;
    if (frm_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL alt_frm_valid got %b want 1", frm_valid);
    end
    tests_run++;
    if (frm_data !== {392{2'b10}}) begin
      tests_failed++;
      $display("FAIL alt_frm_data got %h want pattern 1010..", frm_data[31:0]);
    end
    tests_run++;
    if (pix_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL alt_pix_ready_hold got %b want 0", pix_ready);
    end
    @(posedge clk);
    #1;
    frm_ready = 1'b0;
    tests_run++;
    if (frm_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL alt_frm_valid_drop got %b want 0", frm_valid);
    end
    tests_run++;
    if (pix_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL alt_pix_ready_back got %b want 1", pix_ready);
    end
  endtask

  task automatic test_hold();
    int bad;
    for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'h00;
    frm_ready = 1'b0;
    run_frame(8'hFF, 8'hFF);
    tests_run++;
    if (frm_valid !== 1'b1 || frm_data !== '0) begin
      tests_failed++;
      $display("FAIL hold_frame got valid=%b data_lsw=%h want valid=1 data=0",
               frm_valid, frm_data[31:0]);
    end
    // Pixels offered while held must be ignored.
    bad = 0;
    pix_valid = 1'b1;
    pix_data  = 8'hFF;
    thresh    = 8'h00;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (pix_ready !== 1'b0 || frm_valid !== 1'b1 || frm_data !== '0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL hold_stable got %0d bad cycles want 0", bad);
    end
    pix_valid = 1'b0;
    release_frame();
    tests_run++;
    if (pix_ready !== 1'b1 || frm_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_release got ready=%b valid=%b want ready=1 valid=0",
               pix_ready, frm_valid);
    end
  endtask

  task automatic test_thresh_latch();
    for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'h20;
    run_frame(8'h10, 8'hFF);
    tests_run++;
    if (frm_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL thr_frm_valid got %b want 1", frm_valid);
    end
    tests_run++;
    if (frm_data !== {NPIX{1'b1}}) begin
      tests_failed++;
      $display("FAIL thr_frm_data got lsw %h msw %h want all ones",
               frm_data[31:0], frm_data[NPIX-1 -: 32]);
    end
    release_frame();
  endtask

  task automatic test_boundary();
    for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'h00;
    pix_mem[0] = 8'hFE;
    pix_mem[1] = 8'hFF;
    exp_frame = '0;
    exp_frame[1] = 1'b1;
    run_frame(8'hFF, 8'hFF);
    tests_run++;
    if (frm_data[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bnd_fe_vs_ff got %b want 0", frm_data[0]);
    end
    tests_run++;
    if (frm_data !== exp_frame) begin
      tests_failed++;
      $display("FAIL bnd_ff_vs_ff got lsw %h want lsw %h", frm_data[31:0], exp_frame[31:0]);
    end
    release_frame();
    for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'h00;
    run_frame(8'h00, 8'hFF);
    tests_run++;
    if (frm_data[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL bnd_00_vs_00 got %b want 1", frm_data[0]);
    end
    tests_run++;
    if (frm_data !== {NPIX{1'b1}}) begin
      tests_failed++;
      $display("FAIL bnd_latched_zero got lsw %h want all ones", frm_data[31:0]);
    end
    release_frame();
  endtask

  task automatic test_reset_midframe();
    thresh = 8'h00;
    for (int i = 0; i < 300; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'hFF;
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (frm_data !== '0 || frm_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_async got valid=%b data_lsw=%h want 0/0", frm_valid, frm_data[31:0]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      pix_mem[i] = (i % 3 == 0) ? 8'h90 : 8'h10;
      exp_frame[i] = (i % 3 == 0);
    end
    run_frame(8'h80, 8'h80);
    tests_run++;
    if (early_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_early_valid got %b want 0", early_valid);
    end
    tests_run++;
    if (frm_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_frm_valid got %b want 1", frm_valid);
    end
    tests_run++;
    if (frm_data !== exp_frame) begin
      tests_failed++;
      $display("FAIL rst_mid_frm_data got lsw %h want lsw %h", frm_data[31:0], exp_frame[31:0]);
    end
    release_frame();
  endtask

`ifdef MNIST_BIN_FRAMECHK_EN
  task automatic test_framechk();
    early_valid = 1'b0;
    thresh = 8'h00;
    for (int i = 0; i < 100; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'h00;
      pix_last  = (i == 99);
      @(posedge clk);
      #1;
      if (frm_valid) early_valid = 1'b1;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (frm_err !== 1'b1 || frm_valid !== 1'b0 || early_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fc_short got err=%b valid=%b early=%b want 1/0/0",
               frm_err, frm_valid, early_valid);
    end
    for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'hFF;
    run_frame(8'h80, 8'h80);
    tests_run++;
    if (early_valid !== 1'b0 || frm_valid !== 1'b1 || frm_data !== {NPIX{1'b1}}) begin
      tests_failed++;
      $display("FAIL fc_next_frame got early=%b valid=%b lsw=%h want 0/1/all ones",
               early_valid, frm_valid, frm_data[31:0]);
    end
    tests_run++;
    if (frm_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL fc_err_sticky got %b want 1", frm_err);
    end
    release_frame();
  endtask
`endif

  initial begin
    test_reset();
    test_alternating();
    test_hold();
    test_thresh_latch();
    test_boundary();
    test_reset_midframe();
`ifdef MNIST_BIN_FRAMECHK_EN
    test_framechk();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
